// File: rtl/fsm_5_checker_if.sv
// Signal bundle between the regression harness and the fsm_5_checker golden-model monitor.
// The master modport drives the mirrored conditions and DUT state; the slave modport reports the verdicts.
interface fsm_5_checker_if #(
   parameter int NSTATES = 5,
   parameter int YW      = 4,
   parameter int ERRW    = 8
);
   logic [NSTATES-1:0] cond;
   logic [YW-1:0]      y;
   logic               mismatch;
   logic               illegal;
   logic               err_sticky;
   logic [ERRW-1:0]    err_count;
   logic [31:0]        cycles;
   logic [31:0]        first_err_cycle;
   logic [YW-1:0]      first_err_exp;
   logic [YW-1:0]      first_err_obs;

   modport master (
      output cond, y,
      input  mismatch, illegal, err_sticky, err_count,
             cycles, first_err_cycle, first_err_exp, first_err_obs
   );

   modport slave (
      input  cond, y,
      output mismatch, illegal, err_sticky, err_count,
             cycles, first_err_cycle, first_err_exp, first_err_obs
   );
endinterface

// File: rtl/fsm_5_checker.sv
// Golden-model monitor for the 5-state ring FSM: compares the DUT state every cycle and logs the first failure.
// Optional macro FSM_CHECK_RESYNC_EN lets the model realign to a legal observed state after a mismatch.
module fsm_5_checker #(
   parameter int NSTATES = 5,
   parameter int YW      = 4,
   parameter int ERRW    = 8
) (
   input logic           clock,
   input logic           reset,
   fsm_5_checker_if.slave chk
);

   logic [YW-1:0]   exp_q, exp_d;
   logic [31:0]     cycles_q, cycles_d;
   logic            mismatch_q, mismatch_d;
   logic            illegal_q, illegal_d;
   logic            sticky_q, sticky_d;
   logic [ERRW-1:0] err_count_q, err_count_d;
   logic [31:0]     fe_cycle_q, fe_cycle_d;
   logic [YW-1:0]   fe_exp_q, fe_exp_d;
   logic [YW-1:0]   fe_obs_q, fe_obs_d;

   logic            miss;
   logic            ill;
   logic            adv;
   logic [YW-1:0]   base;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      miss        = (chk.y != exp_q);
      ill         = (chk.y >= YW'(NSTATES));
      base        = exp_q;
`ifdef FSM_CHECK_RESYNC_EN
      if (miss && !ill) base = chk.y;
`endif
      // Selecting cond by a loop keeps the index in range for any YW/NSTATES pairing.
      adv = 1'b0;
      for (int k = 0; k < NSTATES; k++) begin
         if (base == YW'(k)) adv = chk.cond[k];
      end

      exp_d = base;
      if (adv) exp_d = (base == YW'(NSTATES - 1)) ? '0 : base + YW'(1);

      cycles_d    = cycles_q + 32'd1;
      mismatch_d  = miss;
      illegal_d   = ill;
      err_count_d = (miss && (err_count_q != '1)) ? err_count_q + ERRW'(1) : err_count_q;

      sticky_d   = sticky_q;
      fe_cycle_d = fe_cycle_q;
      fe_exp_d   = fe_exp_q;
      fe_obs_d   = fe_obs_q;
      if (miss && !sticky_q) begin
         sticky_d   = 1'b1;
         fe_cycle_d = cycles_q;
         fe_exp_d   = exp_q;
         fe_obs_d   = chk.y;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         exp_q       <= '0;
         cycles_q    <= '0;
         mismatch_q  <= 1'b0;
         illegal_q   <= 1'b0;
         sticky_q    <= 1'b0;
         err_count_q <= '0;
         fe_cycle_q  <= '0;
         fe_exp_q    <= '0;
         fe_obs_q    <= '0;
      end else begin
         exp_q       <= exp_d;
         cycles_q    <= cycles_d;
         mismatch_q  <= mismatch_d;
         illegal_q   <= illegal_d;
         sticky_q    <= sticky_d;
         err_count_q <= err_count_d;
         fe_cycle_q  <= fe_cycle_d;
         fe_exp_q    <= fe_exp_d;
         fe_obs_q    <= fe_obs_d;
      end
   end

   assign chk.mismatch        = mismatch_q;
   assign chk.illegal         = illegal_q;
   assign chk.err_sticky      = sticky_q;
   assign chk.err_count       = err_count_q;
   assign chk.cycles          = cycles_q;
   assign chk.first_err_cycle = fe_cycle_q;
   assign chk.first_err_exp   = fe_exp_q;
   assign chk.first_err_obs   = fe_obs_q;

endmodule

// File: tb/tb_fsm_5_checker.sv
// Directed bench for fsm_5_checker: a default-width instance plus an ERRW=2 instance for saturation.
// Expected values are hand-derived; FSM_CHECK_RESYNC_EN selects the resync-build expectations.
module tb_fsm_5_checker;

`ifdef FSM_CHECK_RESYNC_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif

   logic       clock;
   logic       reset;
   logic [4:0] cond;
   logic [3:0] y;

   int checks   = 0;
   int failures = 0;

   fsm_5_checker_if #(.NSTATES(5), .YW(4), .ERRW(8)) m_if ();
   fsm_5_checker_if #(.NSTATES(5), .YW(4), .ERRW(2)) s_if ();

   assign m_if.cond = cond;
   assign m_if.y    = y;
   assign s_if.cond = cond;
   assign s_if.y    = y;

   fsm_5_checker #(.NSTATES(5), .YW(4), .ERRW(8)) dut_main (
      .clock (clock),
      .reset (reset),
      .chk   (m_if)
   );

   fsm_5_checker #(.NSTATES(5), .YW(4), .ERRW(2)) dut_sat (
      .clock (clock),
      .reset (reset),
      .chk   (s_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Apply one cycle of stimulus at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic [4:0] c, input logic [3:0] yy);
      @(negedge clock);
      cond = c;
      y    = yy;
      @(posedge clock);
      #1;
   endtask

   task automatic reset_pulse(input logic [3:0] yy);
      @(negedge clock);
      reset = 1'b1;
      cond  = 5'b11111;
      y     = yy;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_mismatch"},   32'(m_if.mismatch), 32'd0);
      check({tag, "_illegal"},    32'(m_if.illegal), 32'd0);
      check({tag, "_sticky"},     32'(m_if.err_sticky), 32'd0);
      check({tag, "_count"},      32'(m_if.err_count), 32'd0);
      check({tag, "_cycles"},     m_if.cycles, 32'd0);
      check({tag, "_fe_cycle"},   m_if.first_err_cycle, 32'd0);
      check({tag, "_fe_exp"},     32'(m_if.first_err_exp), 32'd0);
      check({tag, "_fe_obs"},     32'(m_if.first_err_obs), 32'd0);
      check({tag, "_sat_count"},  32'(s_if.err_count), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      cond  = 5'b00000;
      y     = 4'd0;

      // Reset state
      reset_pulse(4'd0);
      check_cleared("rst");

      // Correct run through two full wraps
      for (int i = 0; i < 10; i++) begin
         step(5'b11111, 4'(i % 5));
         check("run_mismatch", 32'(m_if.mismatch), 32'd0);
         check("run_illegal",  32'(m_if.illegal), 32'd0);
      end
      check("run_count",  32'(m_if.err_count), 32'd0);
      check("run_sticky", 32'(m_if.err_sticky), 32'd0);
      check("run_cycles", m_if.cycles, 32'd10);

      // Hold: no conditions, state stays 0
      for (int i = 0; i < 8; i++) begin
         step(5'b00000, 4'd0);
         check("hold_mismatch", 32'(m_if.mismatch), 32'd0);
      end
      check("hold_count",  32'(m_if.err_count), 32'd0);
      check("hold_cycles", m_if.cycles, 32'd18);

      // Single fault: DUT reports 2 at cycles=3 where 3 is expected, then keeps its own ring
      reset_pulse(4'd0);
      step(5'b11111, 4'd0);
      step(5'b11111, 4'd1);
      step(5'b11111, 4'd2);
      check("fault_pre_mismatch", 32'(m_if.mismatch), 32'd0);
      step(5'b11111, 4'd2);
      check("fault_mismatch", 32'(m_if.mismatch), 32'd1);
      check("fault_illegal",  32'(m_if.illegal), 32'd0);
      check("fault_sticky",   32'(m_if.err_sticky), 32'd1);
      check("fault_fe_cycle", m_if.first_err_cycle, 32'd3);
      check("fault_fe_exp",   32'(m_if.first_err_exp), 32'd3);
      check("fault_fe_obs",   32'(m_if.first_err_obs), 32'd2);
      check("fault_count1",   32'(m_if.err_count), 32'd1);
      step(5'b11111, 4'd3);
      check("fault_next_mismatch", 32'(m_if.mismatch), RESYNC ? 32'd0 : 32'd1);
      step(5'b11111, 4'd4);
      step(5'b11111, 4'd0);
      step(5'b11111, 4'd1);
      check("fault_count_end", 32'(m_if.err_count), RESYNC ? 32'd1 : 32'd5);
      check("fault_fe_cycle_kept", m_if.first_err_cycle, 32'd3);
      check("fault_fe_obs_kept",   32'(m_if.first_err_obs), 32'd2);
      check("fault_cycles", m_if.cycles, 32'd8);

      // Illegal encoding at cycles=2, then a legal mismatch at cycles=4
      reset_pulse(4'd0);
      step(5'b11111, 4'd0);
      step(5'b11111, 4'd1);
      step(5'b11111, 4'd7);
      check("ill_illegal",  32'(m_if.illegal), 32'd1);
      check("ill_mismatch", 32'(m_if.mismatch), 32'd1);
      check("ill_count",    32'(m_if.err_count), 32'd1);
      check("ill_fe_cycle", m_if.first_err_cycle, 32'd2);
      check("ill_fe_exp",   32'(m_if.first_err_exp), 32'd2);
      check("ill_fe_obs",   32'(m_if.first_err_obs), 32'd7);
      step(5'b11111, 4'd3);
      check("ill_after_illegal",  32'(m_if.illegal), 32'd0);
      check("ill_after_mismatch", 32'(m_if.mismatch), 32'd0);
      step(5'b11111, 4'd0);
      check("ill_second_mismatch", 32'(m_if.mismatch), 32'd1);
      check("ill_second_count",    32'(m_if.err_count), 32'd2);
      check("ill_fe_cycle_kept",   m_if.first_err_cycle, 32'd2);
      check("ill_fe_obs_kept",     32'(m_if.first_err_obs), 32'd7);

      // Saturation: y stuck at 1 while the model keeps advancing
      reset_pulse(4'd0);
      for (int i = 0; i < 6; i++) step(5'b11111, 4'd1);
      check("sat_count6",  32'(s_if.err_count), 32'd3);
      check("sat_main6",   32'(m_if.err_count), RESYNC ? 32'd6 : 32'd5);
      for (int i = 0; i < 3; i++) step(5'b11111, 4'd1);
      check("sat_count9",  32'(s_if.err_count), 32'd3);
      check("sat_main9",   32'(m_if.err_count), RESYNC ? 32'd9 : 32'd7);
      check("sat_sticky",  32'(m_if.err_sticky), 32'd1);

      // Reset mid-run with a bad y present: in-flight pulse must be dropped
      reset_pulse(4'd9);
      check_cleared("midrst");
      for (int i = 0; i < 5; i++) begin
         step(5'b11111, 4'(i));
         check("post_mismatch", 32'(m_if.mismatch), 32'd0);
      end
      check("post_sticky", 32'(m_if.err_sticky), 32'd0);
      check("post_count",  32'(m_if.err_count), 32'd0);
      check("post_cycles", m_if.cycles, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fsm_5_checker.md
Name: fsm_5_checker

Overview:
- Hardware consumer for the 5-state FSM block `main` (inputs i0..i4, 4-bit state output y).
- Sits beside the DUT in the regression harness and receives the same condition inputs.
- Runs a golden reference model of the ring FSM, compares y every cycle, and reports mismatches, illegal encodings and first-failure data in registers.
- Lets the bench finish on a single pass/fail check instead of reading $display logs by eye.

Parameters:
- NSTATES, 5: number of FSM states; legal encodings are 0..NSTATES-1.
- YW, 4: width of the observed state bus y.
- ERRW, 8: width of the saturating error counter.

Ports:
- clock  input  1  single design clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cond  input  NSTATES  advance conditions; cond[k] mirrors DUT input ik.
- y  input  YW  DUT state output, observed this cycle.
- mismatch  output  1  one-cycle pulse: y differed from expected in the previous cycle.
- illegal  output  1  one-cycle pulse: y was >= NSTATES in the previous cycle.
- err_sticky  output  1  set on the first mismatch; cleared only by reset.
- err_count  output  ERRW  saturating count of mismatch cycles.
- cycles  output  32  cycles since reset deassertion; 0 in the first compared cycle.
- first_err_cycle  output  32  value of cycles at the first mismatch.
- first_err_exp  output  YW  expected state at the first mismatch.
- first_err_obs  output  YW  observed y at the first mismatch.

Behaviour:
- Reset (synchronous, active-high): model state exp=0, cycles=0, and every output is 0. Reset asserted mid-run clears everything on the next edge and drops in-flight pulses.
- Model: each non-reset edge, exp_next = cond[exp] ? (exp==NSTATES-1 ? 0 : exp+1) : exp.
  - Wrap is explicit, with no modulo operator.
  - exp is YW bits wide and zero-extended for comparison.
- Compare, every non-reset cycle:
  - miss = (y != exp)
  - ill = (y >= NSTATES)
- Outputs are registered, 1-cycle latency: mismatch <= miss, illegal <= ill.
  - An illegal y also counts as a mismatch.
- err_count <= err_count + 1 on miss and holds at all-ones (saturates, no wrap).
- First-error capture: when miss && !err_sticky, latch cycles, exp and y into the first_err_* registers and set err_sticky. Later mismatches never overwrite them.
- The cycles counter increments every non-reset cycle and wraps at 2^32 (no flag).
- Timing contract: y of the compared cycle is the DUT state after the same number of non-reset edges as exp. The DUT resets to state 0.
- Model divergence: by default the model ignores y and keeps its own sequence. A single skipped transition therefore produces a mismatch on every following cycle until the states realign.
- cond values are sampled only to advance the model. X on cond is not handled.

Optional Feature:
- Macro FSM_CHECK_RESYNC_EN.
- Defined: on miss with a legal y (y < NSTATES), exp_next is computed from y instead of exp, so one fault yields one mismatch pulse. On illegal y the model advances from exp as normal.
- Undefined: the model never takes state from y (behaviour above).
- Port list and reset behaviour are identical in both builds.

Test Plan:
- Correct run: cond=5'b11111; y = 0,1,2,3,4,0,1,2,3,4 for 10 cycles -> mismatch and illegal never assert; err_count=0; err_sticky=0; cycles=10.
- Hold: cond=5'b00000; y=0 for 8 cycles -> no errors; exp remains 0.
- Single fault: cond=5'b11111; inject y=2 at cycles=3 (expected 3) -> mismatch=1 at cycles=4; first_err_cycle=3, first_err_exp=3, first_err_obs=2; err_sticky=1.
  - With FSM_CHECK_RESYNC_EN: err_count=1 at end of run.
  - Without it: err_count counts every following divergent cycle.
- Illegal: y=4'd7 at cycles=2 -> illegal=1 and mismatch=1 at cycles=3; err_count increments by 1.
- Saturation: ERRW=2; force y=4'd1 constantly with cond=5'b11111 -> err_count reaches 3 and holds at 3.
- Reset mid-run: after an error, assert reset for 1 cycle -> all outputs 0 on the next edge; a correct sequence afterwards leaves err_sticky=0.
